// File: rtl/subtract_pkg.sv
// Shared types and arithmetic helpers for the background-subtraction engine.
// Helpers work on 32-bit values so any channel width up to 30 bits can reuse them.
package subtract_pkg;

  typedef enum logic [1:0] {
    MODE_DIFF0 = 2'd0,
    MODE_MAX   = 2'd1,
    MODE_MASK  = 2'd2,
    MODE_SUM   = 2'd3
  } mode_e;

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Adding non-negative values with saturation at each step equals saturating the total.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] limit;
    sum   = {1'b0, a} + {1'b0, b};
    limit = (33'd1 << width) - 33'd1;
    return (sum > limit) ? limit[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/subtract_out_fifo.sv
// Synchronous result FIFO with occupancy count; head entry is presented combinationally.
// Pops on an empty FIFO are ignored, so the consumer may hold pop high freely.
module subtract_out_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     pop_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_pop;

  assign pop_valid = (count != '0);
  assign do_pop    = pop && pop_valid;
  assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/subtract_stream.sv
// Joins background and current pixel streams, reduces per-channel absolute differences
// to one mask value through a two-stage pipeline, and buffers results in a credit-managed FIFO.
module subtract_stream
  import subtract_pkg::*;
#(
  parameter int CHANNELS  = 3,
  parameter int CH_WIDTH  = 8,
  parameter int WIDTH     = 768,
  parameter int HEIGHT    = 576,
  parameter int OUT_DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:0]                   mode,
  input  logic [CH_WIDTH-1:0]          threshold,
  input  logic                         base_valid,
  output logic                         base_ready,
  input  logic [CHANNELS*CH_WIDTH-1:0] base_data,
  input  logic                         img_valid,
  output logic                         img_ready,
  input  logic [CHANNELS*CH_WIDTH-1:0] img_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_WIDTH-1:0]          out_data,
  output logic                         out_last,
  output logic                         frame_done
);

  localparam int FRAME_PIXELS = WIDTH * HEIGHT;
  localparam int CNT_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int AW           = $clog2(OUT_DEPTH);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  logic [AW:0]                         fifo_count;
  logic [AW+1:0]                       occupancy;
  logic                                ready;
  logic                                accept;
  logic [CNT_W-1:0]                    pix_cnt;
  logic                                pix_last;
  mode_e                               frame_mode;
  logic [CH_WIDTH-1:0]                 frame_thr;
  mode_e                               pix_mode;
  logic [CH_WIDTH-1:0]                 pix_thr;
  logic [CHANNELS-1:0][CH_WIDTH-1:0]   diff_comb;

  logic                                s1_valid;
  logic [CHANNELS-1:0][CH_WIDTH-1:0]   s1_diff;
  mode_e                               s1_mode;
  logic [CH_WIDTH-1:0]                 s1_thr;
  logic                                s1_last;

  logic [CH_WIDTH-1:0]                 max_diff;
  logic [31:0]                         sum_acc;
  logic [CH_WIDTH-1:0]                 stage2_data;

  logic                                s2_valid;
  logic [CH_WIDTH-1:0]                 s2_data;
  logic                                s2_last;

  // Every accepted pixel reserves a FIFO slot, so the pipeline never needs to stall.
  assign occupancy  = (AW + 2)'(fifo_count) + (AW + 2)'(s1_valid) + (AW + 2)'(s2_valid);
  assign ready      = occupancy < (AW + 2)'(OUT_DEPTH);
  assign base_ready = ready;
  assign img_ready  = ready;
  assign accept     = base_valid && img_valid && ready;

  assign pix_last = (pix_cnt == LAST_PIX);
  assign pix_mode = (pix_cnt == '0) ? mode_e'(mode) : frame_mode;
  assign pix_thr  = (pix_cnt == '0) ? threshold : frame_thr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_cnt    <= '0;
      frame_mode <= MODE_DIFF0;
      frame_thr  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && pix_last;
      if (accept) begin
        pix_cnt <= pix_last ? '0 : pix_cnt + CNT_W'(1);
        if (pix_cnt == '0) begin
          frame_mode <= mode_e'(mode);
          frame_thr  <= threshold;
        end
      end
    end
  end

  always_comb begin
    diff_comb = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      diff_comb[c] = CH_WIDTH'(abs_diff(32'(img_data[c*CH_WIDTH +: CH_WIDTH]),
                                        32'(base_data[c*CH_WIDTH +: CH_WIDTH])));
    end
  end

  // Mode and threshold travel with the pixel so a frame boundary inside the pipe is harmless.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s1_mode  <= MODE_DIFF0;
      s1_thr   <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_diff <= diff_comb;
        s1_mode <= pix_mode;
        s1_thr  <= pix_thr;
        s1_last <= pix_last;
      end
    end
  end

  always_comb begin
    max_diff = '0;
    sum_acc  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (s1_diff[c] > max_diff) begin
        max_diff = s1_diff[c];
      end
      sum_acc = sat_add(sum_acc, 32'(s1_diff[c]), CH_WIDTH);
    end
    stage2_data = s1_diff[0];
    case (s1_mode)
      MODE_DIFF0: stage2_data = s1_diff[0];
      MODE_MAX:   stage2_data = max_diff;
      MODE_MASK:  stage2_data = (max_diff > s1_thr) ? '1 : '0;
      MODE_SUM:   stage2_data = CH_WIDTH'(sum_acc);
      default:    stage2_data = s1_diff[0];
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_last  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= stage2_data;
        s2_last <= s1_last;
      end
    end
  end

  subtract_out_fifo #(
    .DATA_W (CH_WIDTH + 1),
    .DEPTH  (OUT_DEPTH)
  ) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (s2_valid),
    .push_data ({s2_last, s2_data}),
    .pop       (out_ready),
    .pop_data  ({out_last, out_data}),
    .pop_valid (out_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_subtract_stream.sv
// Self-checking bench for subtract_stream: directed scenarios plus random traffic,
// compared every cycle against an outstanding-result queue model.
module tb_subtract_stream;

  localparam int CHANNELS  = 3;
  localparam int CH_WIDTH  = 8;
  localparam int WIDTH     = 4;
  localparam int HEIGHT    = 2;
  localparam int OUT_DEPTH = 8;
  localparam int FRAME     = WIDTH * HEIGHT;

  logic        clock;
  logic        reset;
  logic [1:0]  mode;
  logic [7:0]  threshold;
  logic        base_valid;
  logic        base_ready;
  logic [23:0] base_data;
  logic        img_valid;
  logic        img_ready;
  logic [23:0] img_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        frame_done;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         k;
  } exp_t;

  exp_t       exp_q[$];
  int         checks;
  int         failures;
  int         edge_count;
  int         m_pix;
  int         fd_count;
  logic [1:0] m_mode;
  logic [7:0] m_thr;
  logic       exp_fd;

  subtract_stream #(
    .CHANNELS  (CHANNELS),
    .CH_WIDTH  (CH_WIDTH),
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mode       (mode),
    .threshold  (threshold),
    .base_valid (base_valid),
    .base_ready (base_ready),
    .base_data  (base_data),
    .img_valid  (img_valid),
    .img_ready  (img_ready),
    .img_data   (img_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] ref_value(input logic [23:0] b, input logic [23:0] im,
                                           input logic [1:0] md, input logic [7:0] th);
    int d0;
    int mx;
    int sum;
    d0  = 0;
    mx  = 0;
    sum = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      int bv;
      int iv;
      int d;
      bv = int'(b[c*8 +: 8]);
      iv = int'(im[c*8 +: 8]);
      d  = (bv > iv) ? bv - iv : iv - bv;
      if (c == 0) d0 = d;
      if (d > mx) mx = d;
      sum += d;
    end
    case (md)
      2'd0:    return 8'(d0);
      2'd1:    return 8'(mx);
      2'd2:    return (mx > int'(th)) ? 8'hFF : 8'h00;
      default: return (sum > 255) ? 8'hFF : 8'(sum);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input logic exp_ready, input logic exp_valid);
    check("base_ready", 32'(base_ready), 32'(exp_ready));
    check("img_ready", 32'(img_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    if (exp_valid) begin
      check("out_data", 32'(out_data), 32'(exp_q[0].data));
      check("out_last", 32'(out_last), 32'(exp_q[0].last));
    end
    if (frame_done === 1'b1) fd_count++;
  endtask

  // One cycle: drive at the falling edge, check, then fold the rising edge into the model.
  task automatic applyStimulus(input logic bv, input logic iv, input logic [23:0] bd,
                               input logic [23:0] id, input logic ordy,
                               input logic [1:0] md, input logic [7:0] th);
    logic exp_ready;
    logic exp_valid;
    logic acc;
    logic pop;
    logic last;
    base_valid = bv;
    img_valid  = iv;
    base_data  = bd;
    img_data   = id;
    out_ready  = ordy;
    mode       = md;
    threshold  = th;
    #1;
    exp_ready = (exp_q.size() < OUT_DEPTH);
    exp_valid = 1'b0;
    if (exp_q.size() > 0) exp_valid = (exp_q[0].k <= edge_count - 2);
    checkOutput(exp_ready, exp_valid);
    acc  = bv && iv && exp_ready;
    pop  = exp_valid && ordy;
    last = 1'b0;
    @(posedge clock);
    edge_count++;
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      if (m_pix == 0) begin
        m_mode = md;
        m_thr  = th;
      end
      last = (m_pix == FRAME - 1);
      exp_q.push_back('{data: ref_value(bd, id, m_mode, m_thr), last: last, k: edge_count});
      m_pix = last ? 0 : m_pix + 1;
    end
    exp_fd = acc && last;
    @(negedge clock);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 24'h0, 24'h0, ordy, 2'd0, 8'd0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    base_valid = 1'b0;
    img_valid  = 1'b0;
    out_ready  = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    edge_count = 0;
    m_pix  = 0;
    m_mode = 2'd0;
    m_thr  = 8'd0;
    exp_fd = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    fd_count = 0;
    mode = 2'd0;
    threshold = 8'd0;
    base_data = 24'h0;
    img_data = 24'h0;
    @(negedge clock);
    doReset();
    check("rst_ready", 32'(img_ready), 32'd1);

    // Mask mode, threshold 20: diff 0x15 masks to ones, diff 0x10 to zero.
    for (int i = 0; i < FRAME; i++)
      applyStimulus(1'b1, 1'b1, 24'h101010, (i % 2 == 0) ? 24'h252525 : 24'h202020,
                    1'b1, 2'd2, 8'd20);
    idle(6, 1'b1);
    check("frame_done_pulses", 32'(fd_count), 32'd1);

    // Sum mode with saturation.
    for (int i = 0; i < FRAME; i++)
      applyStimulus(1'b1, 1'b1, 24'h000000, (i % 2 == 0) ? 24'hC0C0C0 : 24'h101010,
                    1'b1, 2'd3, 8'd0);
    idle(6, 1'b1);

    // Backpressure: exactly OUT_DEPTH results accepted before ready drops.
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 1'b1, 24'($urandom), 24'($urandom), 1'b0, 2'd1, 8'd0);
    #1;
    check("ready_when_full", 32'(img_ready), 32'd0);
    check("valid_when_full", 32'(out_valid), 32'd1);
    @(negedge clock);
    idle(12, 1'b1);

    // Join: lone base_valid is held off until img_valid arrives.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b0, 24'h123456, 24'h654321, 1'b1, 2'd0, 8'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 24'($urandom), 24'($urandom), 1'b1, 2'd0, 8'd0);
    idle(5, 1'b1);

    while (m_pix != 0)
      applyStimulus(1'b1, 1'b1, 24'($urandom), 24'($urandom), 1'b1, 2'd3, 8'd0);

    // Mode change at pixel 3 only takes effect on the next frame.
    for (int i = 0; i < 2 * FRAME; i++)
      applyStimulus(1'b1, 1'b1, 24'($urandom), 24'($urandom), 1'b1,
                    (i < 3) ? 2'd0 : 2'd1, 8'd0);
    idle(5, 1'b1);

    // Random traffic with random backpressure, modes and thresholds.
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(3) != 0), ($urandom_range(3) != 0),
                    24'($urandom), 24'($urandom), ($urandom_range(2) != 0),
                    2'($urandom), 8'($urandom));
    idle(12, 1'b1);

    // Mid-frame reset with results waiting in the FIFO.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 24'($urandom), 24'($urandom), 1'b0, 2'd1, 8'd0);
    idle(3, 1'b0);
    doReset();
    for (int i = 0; i < FRAME + 3; i++)
      applyStimulus(1'b1, 1'b1, 24'($urandom), 24'($urandom), 1'b1, 2'd2, 8'd40);
    idle(8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
